// File: rtl/hwpe_color_converter_engine.sv
// Streaming multi-mode colour converter: pass-through, RGB->YCbCr (BT.601 Q8), RGB->grey, RGB->BGR.
// Two-stage stall-capable pipeline (products, then sum/shift/clamp), PIX pixels per beat.

module hwpe_ccv_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        s1_en,
    input  logic        s2_en,
    input  logic [1:0]  s1_mode,
    input  logic [23:0] pix_in,
    output logic [23:0] pix_out
);
    logic signed [17:0] r, g, b;
    logic signed [17:0] prod_q [9];
    logic [23:0]        raw_q;
    logic signed [17:0] y_sh, cb_sh, cr_sh;
    logic [7:0]         y8, cb8, cr8;
    logic [23:0]        res;

    assign r = $signed({10'd0, pix_in[7:0]});
    assign g = $signed({10'd0, pix_in[15:8]});
    assign b = $signed({10'd0, pix_in[23:16]});

    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        if (v < 18'sd0)        return 8'd0;
        else if (v > 18'sd255) return 8'd255;
        else                   return v[7:0];
    endfunction

    // Stage 1: coefficient products, negative terms stored already negated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            raw_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            raw_q <= '0;
        end else if (s1_en) begin
            prod_q[0] <= 18'sd77 * r;
            prod_q[1] <= 18'sd150 * g;
            prod_q[2] <= 18'sd29 * b;
            prod_q[3] <= -18'sd43 * r;
            prod_q[4] <= -18'sd85 * g;
            prod_q[5] <= 18'sd128 * b;
            prod_q[6] <= 18'sd128 * r;
            prod_q[7] <= -18'sd107 * g;
            prod_q[8] <= -18'sd21 * b;
            raw_q     <= pix_in;
        end
    end

    assign y_sh  = (prod_q[0] + prod_q[1] + prod_q[2] + 18'sd128) >>> 8;
    assign cb_sh = ((prod_q[3] + prod_q[4] + prod_q[5] + 18'sd128) >>> 8) + 18'sd128;
    assign cr_sh = ((prod_q[6] + prod_q[7] + prod_q[8] + 18'sd128) >>> 8) + 18'sd128;
    assign y8    = clamp8(y_sh);
    assign cb8   = clamp8(cb_sh);
    assign cr8   = clamp8(cr_sh);

    always_comb begin
        res = raw_q;
        case (s1_mode)
            2'd1:    res = {cr8, cb8, y8};
            2'd2:    res = {y8, y8, y8};
            2'd3:    res = {raw_q[7:0], raw_q[15:8], raw_q[23:16]};
            default: res = raw_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pix_out <= '0;
        else if (clear) pix_out <= '0;
        else if (s2_en) pix_out <= res;
    end
endmodule

module hwpe_color_converter_engine #(
    parameter int STREAM_WIDTH = 96,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [STREAM_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [STREAM_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);
    localparam int PIX    = STREAM_WIDTH / 24;
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_inc;
    logic [1:0]           mode_q, s1_mode_q;
    logic [STAGES:1]      vld_pipe, last_pipe;
    logic                 done_q, done_d;
    logic                 s1_adv, s2_adv, in_fire, out_fire, beat_last;

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = (state_q == RUN) && s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign cnt_inc   = cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    // cnt_q never exceeds len-1 while in RUN, so cnt_inc cannot wrap
    assign beat_last = (cnt_inc == len_q);

    assign out_valid = vld_pipe[2];
    assign out_last  = last_pipe[2];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (len != '0) state_d = RUN;
                    else           done_d  = 1'b1;
                end
                RUN:   if (in_fire && beat_last) state_d = DRAIN;
                DRAIN: if (out_fire && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && start && len != '0) begin
            len_q  <= len;
            mode_q <= mode;
            cnt_q  <= '0;
        end else if (in_fire) begin
            cnt_q <= cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s1_mode_q <= '0;
        end else if (clear) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s1_mode_q <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1]  <= in_fire;
                last_pipe[1] <= in_fire && beat_last;
            end
            if (in_fire) s1_mode_q <= mode_q;
            if (s2_adv) begin
                vld_pipe[2]  <= vld_pipe[1];
                last_pipe[2] <= last_pipe[1];
            end
        end
    end

    for (genvar k = 0; k < PIX; k++) begin : g_lane
        hwpe_ccv_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .s1_en   (in_fire),
            .s2_en   (s2_adv && vld_pipe[1]),
            .s1_mode (s1_mode_q),
            .pix_in  (in_data[24*k +: 24]),
            .pix_out (out_data[24*k +: 24])
        );
    end
endmodule

// File: tb/tb_hwpe_color_converter_engine.sv
// Directed bench for hwpe_color_converter_engine with a scoreboard queue fed on input handshakes.
module tb_hwpe_color_converter_engine;
    localparam int SW  = 96;
    localparam int LW  = 16;
    localparam int PIX = SW / 24;

    logic          clk = 1'b0;
    logic          rst, clear, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
    logic [1:0]    mode;
    logic [LW-1:0] len;
    logic [SW-1:0] in_data, out_data;

    int total = 0, bad = 0, cyc_n = 0;
    logic [SW:0]   sb[$];
    logic [SW-1:0] tx_q[$];
    logic [1:0]    cur_mode;
    int            cur_len, beat_idx;
    bit            acc, done_seen, busy_seen, inr_seen, ov_seen, prev_stall, prev_last;
    logic [SW-1:0] prev_data, last_out;
    int            n_out, n_done, in_cyc, out_cyc, done_cyc, first_out;

    always #5 clk = ~clk;

    hwpe_color_converter_engine #(.STREAM_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    function automatic logic [SW-1:0] model(input logic [SW-1:0] d, input logic [1:0] m);
        logic [SW-1:0] o;
        int r, g, b, y, cb, cr;
        o = '0;
        for (int k = 0; k < PIX; k++) begin
            r  = int'(d[24*k +: 8]);
            g  = int'(d[24*k+8 +: 8]);
            b  = int'(d[24*k+16 +: 8]);
            y  = clamp((77*r + 150*g + 29*b + 128) >>> 8);
            cb = clamp(((-43*r - 85*g + 128*b + 128) >>> 8) + 128);
            cr = clamp(((128*r - 107*g - 21*b + 128) >>> 8) + 128);
            case (m)
                2'd1:    o[24*k +: 24] = {cr[7:0], cb[7:0], y[7:0]};
                2'd2:    o[24*k +: 24] = {y[7:0], y[7:0], y[7:0]};
                2'd3:    o[24*k +: 24] = {r[7:0], g[7:0], b[7:0]};
                default: o[24*k +: 24] = d[24*k +: 24];
            endcase
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [SW:0] e;
        acc = 1'b0;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
        end
        prev_stall = out_valid && !out_ready && !clear;
        prev_data  = out_data;
        prev_last  = out_last;
        if (busy)      busy_seen = 1'b1;
        if (in_ready)  inr_seen  = 1'b1;
        if (out_valid) ov_seen   = 1'b1;
        if (done) begin
            n_done++;
            done_seen = 1'b1;
            done_cyc  = cyc_n;
        end
        if (out_valid && out_ready) begin
            n_out++;
            out_cyc  = cyc_n;
            last_out = out_data;
            if (n_out == 1) first_out = cyc_n;
            if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("out_data", out_data, e[SW-1:0]);
                chk("out_last", out_last, e[SW]);
            end
        end
        if (in_valid && in_ready) begin
            beat_idx++;
            acc    = 1'b1;
            in_cyc = cyc_n;
            sb.push_back({beat_idx == cur_len, model(in_data, cur_mode)});
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic start_job(input logic [1:0] m, input int l);
        mode = m; len = LW'(l); start = 1'b1;
        cur_mode = m; cur_len = l; beat_idx = 0;
        done_seen = 0; n_done = 0; n_out = 0; busy_seen = 0; inr_seen = 0; ov_seen = 0;
        cyc();
        start = 1'b0;
    endtask

    task automatic run(input bit rnd_rdy, input bit rnd_vld, input int start_at, input int budget);
        int i = 0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            in_valid  = (i < tx_q.size()) && (!rnd_vld || $urandom_range(0, 1) == 1);
            in_data   = in_valid ? tx_q[i] : '0;
            out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            start     = (c == start_at);
            if (c == start_at) mode = 2'd1;
            cyc();
            if (acc) i++;
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        chk("job_done", done_seen, 1'b1);
        chk("done_once", n_done, 1);
        chk("sb_empty", sb.size(), 0);
        tx_q.delete();
    endtask

    initial begin
        int got;
        rst = 1'b1; clear = 1'b0; start = 1'b0; mode = '0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cur_mode = '0; cur_len = 0; beat_idx = 0; prev_stall = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        cyc(); cyc();

        // mode 1 known pixels, latency checks
        tx_q.push_back(96'hFF0000_0000FF_000000_FFFFFF);
        start_job(2'd1, 1);
        chk("t1_busy_rise", busy, 1'b1);
        run(0, 0, -1, 20);
        chk("t1_data", last_out, 96'h6BFF1D_FF554D_808000_8080FF);
        chk("t1_out_lat", out_cyc - in_cyc, 2);
        chk("t1_done_lat", done_cyc - in_cyc, 3);
        chk("t1_busy_fall", busy, 1'b0);
        cyc();

        // mode 2, random pixels, random backpressure and valid gaps
        for (int k = 0; k < 4; k++) tx_q.push_back({$urandom, $urandom, $urandom});
        start_job(2'd2, 4);
        run(1, 1, -1, 300);
        chk("t2_nout", n_out, 4);
        cyc();

        // mode 0 back-to-back, 64 beats
        for (int k = 0; k < 64; k++) tx_q.push_back({$urandom, $urandom, $urandom});
        start_job(2'd0, 64);
        run(0, 0, -1, 300);
        chk("t3_nout", n_out, 64);
        chk("t3_consecutive", out_cyc - first_out, 63);
        cyc();

        // mode 3 with an ignored start (mode 1) during RUN
        for (int k = 0; k < 5; k++) tx_q.push_back({$urandom, $urandom, $urandom});
        start_job(2'd3, 5);
        run(1, 0, 2, 300);
        chk("t4_nout", n_out, 5);
        cyc();

        // clear with two beats in flight, then a fresh job
        tx_q.push_back({$urandom, $urandom, $urandom});
        tx_q.push_back({$urandom, $urandom, $urandom});
        start_job(2'd0, 4);
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            in_valid = 1'b1; in_data = tx_q[got]; out_ready = 1'b0;
            cyc();
            if (acc) got++;
        end
        chk("t5_accepted", got, 2);
        in_valid = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0; out_ready = 1'b1;
        sb.delete(); tx_q.delete();
        cyc(); cyc();
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_out_last", out_last, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_in_ready", in_ready, 1'b0);
        chk("t5_no_done", n_done, 0);
        tx_q.push_back({$urandom, $urandom, $urandom});
        tx_q.push_back({$urandom, $urandom, $urandom});
        start_job(2'd1, 2);
        run(0, 0, -1, 50);
        chk("t5_nout", n_out, 2);
        cyc();

        // len=0 completes immediately
        start_job(2'd0, 0);
        repeat (4) cyc();
        chk("t6_done_once", n_done, 1);
        chk("t6_busy", busy_seen, 1'b0);
        chk("t6_in_ready", inr_seen, 1'b0);
        chk("t6_out_valid", ov_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
